// File: rtl/measure_pkg.sv
// Shared types and constants for the measure unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package measure_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2,
        SETTLE    = 2'd3
    } dac_arb_state_t;

    // Threshold width matches the channel measure controller's threshold port.
    localparam int DAC_W_DEFAULT  = 16;
    localparam int SETTLE_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after ptr_i, scanning upward with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_pick #(
    parameter int N_CH  = 4,
    parameter int PTR_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             any_o,
    output logic [PTR_W-1:0] idx_o
);

    int w_pos;

    // Walk offsets from farthest to nearest so the nearest hit overrides the rest.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        w_pos = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_pos = int'(ptr_i) + k;
            if (w_pos >= N_CH) begin
                w_pos = w_pos - N_CH;
            end
            if (req_i[w_pos]) begin
                any_o = 1'b1;
                idx_o = PTR_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/dac_share_arb.sv
// Shares one threshold DAC among N_CH channels: captures posted writes, serialises them round-robin.
// Latency: strobe -> dac_req_o in 2 cycles when idle; rdy returns SETTLE_CYCLES+1 cycles after done.
// Backpressure: dac_req_o held until dac_ack_i; per-channel rdy low while a write is pending or in flight.
module dac_share_arb
    import measure_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DAC_W         = DAC_W_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [N_CH*DAC_W-1:0]     ch_threshold_i,
    input  logic [N_CH-1:0]           ch_threshold_wre_i,
    output logic [N_CH-1:0]           ch_threshold_rdy_o,
    output logic [DAC_W-1:0]          dac_data_o,
    output logic [$clog2(N_CH)-1:0]   dac_addr_o,
    output logic                      dac_req_o,
    input  logic                      dac_ack_i,
    input  logic                      dac_done_i
);

    localparam int PTR_W = $clog2(N_CH);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    dac_arb_state_t     r_state;
    logic [N_CH-1:0]    r_pend;
    logic [DAC_W-1:0]   r_val [N_CH];
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req;
    logic [DAC_W-1:0]   r_data;
    logic [PTR_W-1:0]   r_addr;
    logic [N_CH-1:0]    r_rdy;

    logic               w_any;
    logic [PTR_W-1:0]   w_idx;
    logic               w_grant;
    logic [N_CH-1:0]    w_pend_nxt;
    logic               w_busy_nxt;
    logic [PTR_W-1:0]   w_gnt_nxt;

    rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (r_pend),
        .ptr_i (r_ptr),
        .any_o (w_any),
        .idx_o (w_idx)
    );

    assign w_grant   = (r_state == IDLE) && w_any;
    assign w_gnt_nxt = w_grant ? w_idx : r_gnt;

    // Pending flags: a new strobe wins over the grant clearing the same channel.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_threshold_wre_i[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_grant && (w_idx == PTR_W'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    // Whether the FSM will be away from IDLE next cycle; feeds the registered rdy.
    always_comb begin
        w_busy_nxt = 1'b0;
        case (r_state)
            IDLE:      w_busy_nxt = w_any;
            REQ:       w_busy_nxt = 1'b1;
            WAIT_DONE: w_busy_nxt = !(dac_done_i && (SETTLE_CYCLES == 0));
            SETTLE:    w_busy_nxt = (r_cnt != '0);
            default:   w_busy_nxt = 1'b0;
        endcase
    end

    // Per-channel capture of posted thresholds; newest strobe overwrites.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_pend <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_val[i] <= '0;
            end
        end else begin
            r_pend <= w_pend_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (ch_threshold_wre_i[i]) begin
                    r_val[i] <= ch_threshold_i[i*DAC_W +: DAC_W];
                end
            end
        end
    end

    // Transaction FSM: grant, hold request until ack, wait for done, then settle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_idx;
                        r_data  <= r_val[w_idx];
                        r_addr  <= w_idx;
                        r_ptr   <= (w_idx == PTR_W'(N_CH - 1)) ? '0 : w_idx + PTR_W'(1);
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (dac_ack_i) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (dac_done_i) begin
                        if (SETTLE_CYCLES == 0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // rdy registered from next-cycle pending/in-flight status so it tracks state with no lag.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rdy <= '1;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_rdy[i] <= !w_pend_nxt[i] && !(w_busy_nxt && (w_gnt_nxt == PTR_W'(i)));
            end
        end
    end

    assign ch_threshold_rdy_o = r_rdy;
    assign dac_data_o         = r_data;
    assign dac_addr_o         = r_addr;
    assign dac_req_o          = r_req;

endmodule

// File: tb/tb_dac_share_arb.sv
// Bench for dac_share_arb: directed scenarios plus randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: bench plays the DAC driver with immediate or random ack/done delays.
module tb_dac_share_arb;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           arst;
    logic [N*W-1:0] thr;
    logic [N-1:0]   wre;
    logic           ack;
    logic           done;

    logic [N-1:0]   rdy0, rdy4;
    logic [W-1:0]   data0, data4;
    logic [1:0]     addr0, addr4;
    logic           req0, req4;

    logic           sel;
    logic [N-1:0]   rdy_s;
    logic [W-1:0]   data_s;
    logic [1:0]     addr_s;
    logic           req_s;

    int checks = 0;
    int passed = 0;
    int got_addr[$];
    int got_data[$];
    int first_hi;
    int last_done;

    always #5 clk = ~clk;

    assign rdy_s  = sel ? rdy4  : rdy0;
    assign data_s = sel ? data4 : data0;
    assign addr_s = sel ? addr4 : addr0;
    assign req_s  = sel ? req4  : req0;

    dac_share_arb #(.N_CH(N), .DAC_W(W), .SETTLE_CYCLES(0)) dut0 (
        .clk_i(clk), .arst_i(arst), .ch_threshold_i(thr), .ch_threshold_wre_i(wre),
        .ch_threshold_rdy_o(rdy0), .dac_data_o(data0), .dac_addr_o(addr0),
        .dac_req_o(req0), .dac_ack_i(ack), .dac_done_i(done));

    dac_share_arb #(.N_CH(N), .DAC_W(W), .SETTLE_CYCLES(4)) dut4 (
        .clk_i(clk), .arst_i(arst), .ch_threshold_i(thr), .ch_threshold_wre_i(wre),
        .ch_threshold_rdy_o(rdy4), .dac_data_o(data4), .dac_addr_o(addr4),
        .dac_req_o(req4), .dac_ack_i(ack), .dac_done_i(done));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wre  = '0;
        ack  = 1'b0;
        done = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [W-1:0] v);
        wre[ch]        = 1'b1;
        thr[ch*W +: W] = v;
    endtask

    task automatic do_reset();
        idle_in();
        arst = 1'b1;
        cyc();
        cyc();
        arst = 1'b0;
    endtask

    // Immediate-response DAC driver; records every new request and rdy/done timing.
    task automatic collect(input int ncyc, input int watch);
        int  rs;
        logic prev;
        rs = 0;
        prev = 1'b0;
        got_addr.delete();
        got_data.delete();
        first_hi = -1;
        last_done = -1;
        for (int k = 0; k < ncyc; k++) begin
            idle_in();
            if (rs == 1) begin
                ack = 1'b1;
                rs = 2;
            end else if (rs == 2) begin
                done = 1'b1;
                last_done = k;
                rs = 0;
            end
            @(negedge clk);
            if (req_s && !prev) begin
                got_addr.push_back(int'(addr_s));
                got_data.push_back(int'(data_s));
            end
            prev = req_s;
            if (rs == 0 && req_s) rs = 1;
            if (first_hi < 0 && rdy_s[watch]) first_hi = k;
            cyc();
        end
        idle_in();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdy0 !== 4'hF) $display("FAIL reset_rdy0 got %h exp f", rdy0); else passed++;
        checks++; if (rdy4 !== 4'hF) $display("FAIL reset_rdy4 got %h exp f", rdy4); else passed++;
        checks++; if (req0 !== 1'b0 || req4 !== 1'b0) $display("FAIL reset_req got %b%b exp 00", req0, req4); else passed++;
        checks++; if (data0 !== 16'h0 || data4 !== 16'h0) $display("FAIL reset_data got %h %h exp 0", data0, data4); else passed++;
        checks++; if (addr0 !== 2'd0 || addr4 !== 2'd0) $display("FAIL reset_addr got %0d %0d exp 0", addr0, addr4); else passed++;
    endtask

    task automatic test_single();
        sel = 1'b1;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            idle_in();
            if (c == 0) strobe(1, 16'h1234);
            if (c == 3) ack = 1'b1;
            if (c == 6) done = 1'b1;
            checks++; if (req_s !== (c == 2 || c == 3)) $display("FAIL single_req c%0d got %b", c, req_s); else passed++;
            if (c == 2) begin
                checks++; if (addr_s !== 2'd1) $display("FAIL single_addr got %0d exp 1", addr_s); else passed++;
                checks++; if (data_s !== 16'h1234) $display("FAIL single_data got %h exp 1234", data_s); else passed++;
            end
            checks++; if (rdy_s[1] !== !(c >= 1 && c <= 10)) $display("FAIL single_rdy1 c%0d got %b", c, rdy_s[1]); else passed++;
            cyc();
        end
    endtask

    task automatic test_round_robin();
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) strobe(i, 16'(16'h0100 + i));
        cyc();
        collect(40, 0);
        checks++; if (got_addr.size() != 4) $display("FAIL rr1_count got %0d exp 4", got_addr.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_addr[i] != i || got_data[i] != 16'h0100 + i)
                $display("FAIL rr1_order[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], i, 16'h0100 + i); else passed++;
        end
        strobe(1, 16'h0111);
        cyc();
        collect(20, 0);
        checks++; if (got_addr.size() != 1 || got_addr[0] != 1) $display("FAIL rr_ptr_setup got n=%0d a=%0d exp n=1 a=1", got_addr.size(), got_addr[0]); else passed++;
        for (int i = 0; i < N; i++) strobe(i, 16'(16'h0200 + i));
        cyc();
        collect(40, 0);
        checks++; if (got_addr.size() != 4) $display("FAIL rr2_count got %0d exp 4", got_addr.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            int e;
            e = (i + 2) % 4;
            checks++; if (got_addr[i] != e || got_data[i] != 16'h0200 + e)
                $display("FAIL rr2_order[%0d] got %0d/%h exp %0d/%h", i, got_addr[i], got_data[i], e, 16'h0200 + e); else passed++;
        end
    endtask

    task automatic test_overwrite();
        sel = 1'b0;
        do_reset();
        strobe(0, 16'h0005);
        strobe(2, 16'h0010);
        cyc();
        idle_in();
        cyc();
        strobe(2, 16'h0020);
        checks++; if (req_s !== 1'b1 || addr_s !== 2'd0) $display("FAIL ovw_inflight got req=%b a=%0d exp req=1 a=0", req_s, addr_s); else passed++;
        cyc();
        collect(40, 0);
        checks++; if (got_addr.size() != 2) $display("FAIL ovw_count got %0d exp 2", got_addr.size()); else passed++;
        checks++; if (got_addr[0] != 0 || got_data[0] != 16'h0005) $display("FAIL ovw_first got %0d/%h exp 0/0005", got_addr[0], got_data[0]); else passed++;
        checks++; if (got_addr[1] != 2 || got_data[1] != 16'h0020) $display("FAIL ovw_second got %0d/%h exp 2/0020", got_addr[1], got_data[1]); else passed++;
    endtask

    task automatic test_collision();
        sel = 1'b1;
        do_reset();
        strobe(0, 16'hAAAA);
        cyc();
        idle_in();
        strobe(0, 16'hBBBB);
        checks++; if (rdy_s[0] !== 1'b0) $display("FAIL coll_rdy_grant got %b exp 0", rdy_s[0]); else passed++;
        cyc();
        collect(60, 0);
        checks++; if (got_data.size() != 2) $display("FAIL coll_count got %0d exp 2", got_data.size()); else passed++;
        checks++; if (got_data[0] != 16'hAAAA || got_data[1] != 16'hBBBB)
            $display("FAIL coll_data got %h %h exp aaaa bbbb", got_data[0], got_data[1]); else passed++;
        checks++; if (got_addr[0] != 0 || got_addr[1] != 0) $display("FAIL coll_addr got %0d %0d exp 0 0", got_addr[0], got_addr[1]); else passed++;
        checks++; if (first_hi != last_done + 5 || last_done < 0)
            $display("FAIL coll_rdy_release got %0d exp %0d", first_hi, last_done + 5); else passed++;
    endtask

    task automatic test_settle0();
        logic [N-1:0] er;
        sel = 1'b0;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            idle_in();
            if (c == 0)  strobe(1, 16'h0A01);
            if (c == 2 || c == 3) ack = 1'b1;
            if (c == 4 || c == 6 || c == 14) done = 1'b1;
            if (c == 10) strobe(2, 16'h0BEE);
            if (c == 12) begin
                ack = 1'b1;
                done = 1'b1;
            end
            er = 4'hF;
            if (c >= 1 && c <= 4)   er[1] = 1'b0;
            if (c >= 11 && c <= 14) er[2] = 1'b0;
            checks++; if (req_s !== (c == 2 || c == 12)) $display("FAIL s0_req c%0d got %b", c, req_s); else passed++;
            checks++; if (rdy_s !== er) $display("FAIL s0_rdy c%0d got %h exp %h", c, rdy_s, er); else passed++;
            if (c == 12) begin
                checks++; if (addr_s !== 2'd2 || data_s !== 16'h0BEE) $display("FAIL s0_txn got %0d/%h exp 2/0bee", addr_s, data_s); else passed++;
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        do_reset();
        strobe(2, 16'h2222);
        cyc();
        idle_in();
        cyc();
        ack = 1'b1;
        checks++; if (req_s !== 1'b1 || addr_s !== 2'd2) $display("FAIL rm_req got %b/%0d exp 1/2", req_s, addr_s); else passed++;
        cyc();
        idle_in();
        strobe(3, 16'h3333);
        cyc();
        idle_in();
        checks++; if (rdy_s !== 4'b0011) $display("FAIL rm_pre_rdy got %h exp 3", rdy_s); else passed++;
        arst = 1'b1;
        #2;
        checks++; if (rdy_s !== 4'hF) $display("FAIL rm_rdy got %h exp f", rdy_s); else passed++;
        checks++; if (req_s !== 1'b0 || data_s !== 16'h0 || addr_s !== 2'd0)
            $display("FAIL rm_outs got %b/%h/%0d exp 0/0/0", req_s, data_s, addr_s); else passed++;
        cyc();
        arst = 1'b0;
        done = 1'b1;
        cyc();
        idle_in();
        for (int c = 0; c < 10; c++) begin
            checks++; if (req_s !== 1'b0 || rdy_s !== 4'hF) $display("FAIL rm_quiet c%0d got req=%b rdy=%h", c, req_s, rdy_s); else passed++;
            cyc();
        end
        strobe(3, 16'h0303);
        strobe(1, 16'h0101);
        cyc();
        collect(50, 0);
        checks++; if (got_addr.size() != 2) $display("FAIL rm_count got %0d exp 2", got_addr.size()); else passed++;
        checks++; if (got_addr[0] != 1 || got_addr[1] != 3) $display("FAIL rm_order got %0d %0d exp 1 3", got_addr[0], got_addr[1]); else passed++;
    endtask

    // Random traffic; model holds pending values per channel and the rotating start point.
    task automatic test_random();
        bit   [N-1:0] mpend, pw, cw;
        logic [W-1:0] mval [N];
        logic [W-1:0] pv [N];
        logic [W-1:0] cv [N];
        int   mptr, rs, rcnt, nreq;
        logic prev_req;
        sel = 1'b1;
        do_reset();
        mpend = '0; pw = '0; mptr = 0; rs = 0; rcnt = 0; nreq = 0; prev_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            mval[i] = '0; pv[i] = '0;
        end
        for (int t = 0; t < 900; t++) begin
            idle_in();
            if (t < 600) begin
                for (int ch = 0; ch < N; ch++) begin
                    if ($urandom_range(0, 9) == 0) strobe(ch, 16'($urandom));
                end
            end
            cw = wre;
            for (int ch = 0; ch < N; ch++) cv[ch] = thr[ch*W +: W];
            if (rs == 1) begin
                if (rcnt == 0) begin
                    ack = 1'b1; rs = 2; rcnt = $urandom_range(0, 3);
                end else rcnt--;
            end else if (rs == 2) begin
                if (rcnt == 0) begin
                    done = 1'b1; rs = 0;
                end else rcnt--;
            end
            @(negedge clk);
            if (req_s && !prev_req) begin
                int e;
                e = -1;
                nreq++;
                for (int j = 0; j < N; j++) begin
                    if (e < 0 && mpend[(mptr + j) % N]) e = (mptr + j) % N;
                end
                checks++;
                if (e < 0) $display("FAIL rnd_unexpected_req t%0d addr=%0d", t, addr_s);
                else if (addr_s !== 2'(e) || data_s !== mval[e])
                    $display("FAIL rnd_txn t%0d got %0d/%h exp %0d/%h", t, addr_s, data_s, e, mval[e]);
                else passed++;
                if (e >= 0) begin
                    mpend[e] = 1'b0;
                    mptr = (e + 1) % N;
                end
            end
            prev_req = req_s;
            for (int ch = 0; ch < N; ch++) begin
                if (pw[ch]) begin
                    mpend[ch] = 1'b1;
                    mval[ch] = pv[ch];
                end
            end
            pw = cw;
            for (int ch = 0; ch < N; ch++) pv[ch] = cv[ch];
            for (int ch = 0; ch < N; ch++) begin
                if (mpend[ch]) begin
                    checks++; if (rdy_s[ch] !== 1'b0) $display("FAIL rnd_rdy t%0d ch%0d got 1 exp 0", t, ch); else passed++;
                end
            end
            if (rs == 0 && req_s) begin
                rs = 1; rcnt = $urandom_range(0, 3);
            end
            cyc();
        end
        idle_in();
        checks++; if (mpend != '0) $display("FAIL rnd_drain pending model=%b exp 0", mpend); else passed++;
        checks++; if (rdy_s !== 4'hF || req_s !== 1'b0) $display("FAIL rnd_final got rdy=%h req=%b exp f/0", rdy_s, req_s); else passed++;
        checks++; if (nreq < 20) $display("FAIL rnd_activity got %0d exp >=20", nreq); else passed++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel  = 1'b0;
        thr  = '0;
        arst = 1'b1;
        idle_in();
        test_reset();
        test_single();
        test_round_robin();
        test_overwrite();
        test_collision();
        test_settle0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
